// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared datapath width and named 4:1 select encodings.
// Revision : 1.0
// ============================================================================
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mux_2_1.sv
`default_nettype none
// ============================================================================
// Module   : mux_2_1
// Brief    : N-bit 2:1 selector, leaf of the mux_4_1 tree.
// Revision : 1.0
// ============================================================================
module mux_2_1 #(
    parameter int N = 32
) (
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic         s,
    output logic [N-1:0] out
);

    // Ternary keeps an unknown select visible as X on differing bits.
    assign out = s ? in1 : in0;

endmodule
`default_nettype wire

// File: rtl/mux_4_1.sv
`default_nettype none
// ============================================================================
// Module   : mux_4_1
// Brief    : N-bit 4:1 selector with combinational and one-cycle registered outputs.
// Revision : 1.0
// ============================================================================
module mux_4_1
    import mips_pkg::*;
#(
    parameter int N = WORD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    input  logic [1:0]   sel,
    output logic [N-1:0] Z,
    output logic [N-1:0] Z_q
);

    logic [N-1:0] w_ab;
    logic [N-1:0] w_cd;
    logic [N-1:0] w_z;
    logic [N-1:0] r_z_q;

    mux_2_1 #(.N(N)) u_mux_ab (
        .in0 (A),
        .in1 (B),
        .s   (sel[0]),
        .out (w_ab)
    );

    mux_2_1 #(.N(N)) u_mux_cd (
        .in0 (C),
        .in1 (D),
        .s   (sel[0]),
        .out (w_cd)
    );

    mux_2_1 #(.N(N)) u_mux_out (
        .in0 (w_ab),
        .in1 (w_cd),
        .s   (sel[1]),
        .out (w_z)
    );

    // Free-running capture; reset clears the copy without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z_q <= '0;
        end else begin
            r_z_q <= w_z;
        end
    end

    assign Z   = w_z;
    assign Z_q = r_z_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_4_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_4_1
// Brief    : Self-checking bench for mux_4_1 at N=32 and N=8.
// Revision : 1.0
// ============================================================================
module tb_mux_4_1;
    import mips_pkg::*;

    logic        clk    = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst_n  = 1'b0;
    logic [31:0] a, b, c, d;
    logic [1:0]  sel;
    logic [31:0] z, z_q;
    logic [7:0]  z8, z8_q;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_z;
    logic [31:0] exp_q;

    always #5 clk = clk_en ? ~clk : clk;

    mux_4_1 #(.N(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a),
        .B     (b),
        .C     (c),
        .D     (d),
        .sel   (sel),
        .Z     (z),
        .Z_q   (z_q)
    );

    mux_4_1 #(.N(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a[7:0]),
        .B     (b[7:0]),
        .C     (c[7:0]),
        .D     (d[7:0]),
        .sel   (sel),
        .Z     (z8),
        .Z_q   (z8_q)
    );

    // Reference: the select code is simply an index into the list of sources.
    function automatic logic [31:0] pick(input logic [31:0] w0, w1, w2, w3,
                                         input logic [1:0] s);
        logic [31:0] words [4];
        words = '{w0, w1, w2, w3};
        return words[s];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_srcs(input logic [31:0] va, vb, vc, vd);
        a = va; b = vb; c = vc; d = vd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] dec [4];
        logic [1:0]  codes [4];
        codes = '{SEL_A, SEL_B, SEL_C, SEL_D};

        set_srcs(32'd0, 32'd0, 32'd0, 32'd0);
        sel = SEL_A;
        #1;
        check("reset_zq", z_q, 32'd0);
        check("reset_zq8", {24'd0, z8_q}, 32'd0);

        // Static selection with no clock running.
        dec = '{32'd4526, 32'd5659, 32'd745, 32'd2156};
        set_srcs(dec[0], dec[1], dec[2], dec[3]);
        for (int i = 0; i < 4; i++) begin
            sel = codes[i];
            #10;
            check("static_z", z, dec[i]);
        end
        check("static_zq_held", z_q, 32'd0);

        dec = '{32'd4548, 32'd1568, 32'd78515, 32'd1558};
        set_srcs(dec[0], dec[1], dec[2], dec[3]);
        for (int i = 0; i < 4; i++) begin
            sel = codes[i];
            #10;
            check("update_z", z, dec[i]);
        end

        // Registered path.
        rst_n  = 1'b1;
        set_srcs(32'd4526, 32'd5659, 32'd745, 32'd2156);
        sel    = SEL_C;
        clk_en = 1'b1;
        @(posedge clk); #1;
        check("reg_first", z_q, 32'd745);
        @(negedge clk);
        sel = SEL_D;
        #1;
        check("reg_not_early", z_q, 32'd745);
        check("reg_z_now", z, 32'd2156);
        @(posedge clk); #1;
        check("reg_second", z_q, 32'd2156);

        // Asynchronous reset between edges.
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("areset_zq", z_q, 32'd0);
        check("areset_z", z, 32'd2156);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("areset_hold_zq", z_q, 32'd0);
            check("areset_hold_z", z, 32'd2156);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_clk", z_q, 32'd0);
        @(posedge clk); #1;
        check("release_reload", z_q, 32'd2156);

        // All-ones / all-zeros toggle at both widths.
        set_srcs(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sel = (i % 2 == 0) ? SEL_A : SEL_B;
            #1;
            check("ones_z32", z, (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0);
            check("ones_z8", {24'd0, z8}, (i % 2 == 0) ? 32'h0000_00FF : 32'h0);
        end

        // Random stimulus against the reference model.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            set_srcs($urandom, $urandom, $urandom, $urandom);
            sel = 2'($urandom_range(0, 3));
            #1;
            exp_z = pick(a, b, c, d, sel);
            check("rand_z", z, exp_z);
            check("rand_z8", {24'd0, z8}, {24'd0, exp_z[7:0]});
            exp_q = exp_z;
            @(posedge clk); #1;
            check("rand_zq", z_q, exp_q);
            check("rand_zq8", {24'd0, z8_q}, {24'd0, exp_q[7:0]});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
